// File: rtl/lcd_pkg.sv
// Shared types and constants for the serial-LCD transmit path.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    localparam logic [7:0] LCD_CMD_PREFIX = 8'hFE;
    // 10 MHz system clock divided down to 9600 baud.
    localparam int LCD_BAUD_DIV = 1042;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_serial_tx_if.sv
// Write-side valid/ready handshake into the LCD serial transmitter.
interface lcd_serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] WR_DATA;
    logic              WR_VALID;
    logic              WR_READY;

    modport master (output WR_DATA, output WR_VALID, input WR_READY);
    modport slave  (input WR_DATA, input WR_VALID, output WR_READY);
endinterface

// File: rtl/lcd_tx_fifo.sv
// Synchronous FIFO feeding the serialiser; occupancy is kept as a registered count.
module lcd_tx_fifo
    import lcd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int PTR_W = cnt_width(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              do_push;
    logic              do_pop;

    // Full is taken from the registered count, so a pop on the same edge
    // never opens room for a write.
    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/lcd_serial_tx.sv
// Buffered LSB-first serial transmitter toward the LCD, with an idle gap after command bytes.
// Define LCD_SERIAL_TX_PARITY_EN to add an even-parity bit after the data bits.
module lcd_serial_tx
    import lcd_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter int              DEPTH      = 16,
    parameter int              BAUD_DIV   = LCD_BAUD_DIV,
    parameter int              STOP_BITS  = 1,
    parameter logic [DATA_W-1:0] CMD_PREFIX = DATA_W'(LCD_CMD_PREFIX),
    parameter int              GAP_BITS   = 10,
    localparam int             LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic             SYSCLK,
    input  logic             SYSRESET,
    lcd_serial_tx_if.slave   wr,
    output logic             TXD,
    output logic             BUSY,
    output logic [LVL_W-1:0] LEVEL
);

    localparam int CNT_W   = cnt_width(BAUD_DIV);
    localparam int IDX_MAX = (DATA_W > GAP_BITS)
                           ? ((DATA_W > STOP_BITS) ? DATA_W : STOP_BITS)
                           : ((GAP_BITS > STOP_BITS) ? GAP_BITS : STOP_BITS);
    localparam int IDX_W   = cnt_width(IDX_MAX);

    tx_state_e         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              cmd_next, cmd_n;
    logic              cur_cmd, cur_cmd_n;
    logic              cur_pfx, cur_pfx_n;
    logic              txd_n;
    logic              bit_end;
    logic              next_char;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
`ifdef LCD_SERIAL_TX_PARITY_EN
    logic              par, par_n;
`endif

    lcd_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (SYSCLK),
        .rst       (SYSRESET),
        .push      (wr.WR_VALID),
        .push_data (wr.WR_DATA),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (LEVEL)
    );

    assign wr.WR_READY = !fifo_full;
    assign BUSY        = (state != ST_IDLE) || !fifo_empty;
    assign bit_end     = (cnt == CNT_W'(BAUD_DIV - 1));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        idx_n     = idx;
        shift_n   = shift;
        cmd_n     = cmd_next;
        cur_cmd_n = cur_cmd;
        cur_pfx_n = cur_pfx;
        next_char = 1'b0;
        fifo_pop  = 1'b0;
`ifdef LCD_SERIAL_TX_PARITY_EN
        par_n     = par;
`endif
        unique case (state)
            ST_IDLE: begin
                cnt_n     = '0;
                next_char = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = shift >> 1;
                    if (idx == IDX_W'(DATA_W - 1)) begin
                        idx_n = '0;
`ifdef LCD_SERIAL_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
`ifdef LCD_SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        idx_n = '0;
                        // A command byte consumes the flag; a prefix only arms it when it was not itself the command.
                        cmd_n = cur_cmd ? 1'b0 : cur_pfx;
                        if (cur_cmd && (GAP_BITS > 0)) state_n = ST_GAP;
                        else                           next_char = 1'b1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == IDX_W'(GAP_BITS - 1)) next_char = 1'b1;
                    else                             idx_n = idx + IDX_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        // Chain straight into the next START when more data is waiting.
        if (next_char) begin
            state_n = ST_IDLE;
            idx_n   = '0;
            if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                state_n   = ST_START;
                cnt_n     = '0;
                shift_n   = fifo_data;
                cur_pfx_n = (fifo_data == CMD_PREFIX);
                cur_cmd_n = cmd_n;
`ifdef LCD_SERIAL_TX_PARITY_EN
                par_n     = ^fifo_data;
`endif
            end
        end
    end

    // Line level is derived from the next state so TXD is a plain register.
    always_comb begin
        txd_n = 1'b1;
        case (state_n)
            ST_START:  txd_n = 1'b0;
            ST_DATA:   txd_n = shift_n[0];
`ifdef LCD_SERIAL_TX_PARITY_EN
            ST_PARITY: txd_n = par_n;
`endif
            default:   txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            idx      <= '0;
            cmd_next <= 1'b0;
            cur_cmd  <= 1'b0;
            cur_pfx  <= 1'b0;
            TXD      <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            cmd_next <= cmd_n;
            cur_cmd  <= cur_cmd_n;
            cur_pfx  <= cur_pfx_n;
            TXD      <= txd_n;
        end
    end

    always_ff @(posedge SYSCLK) begin
        shift <= shift_n;
    end

`ifdef LCD_SERIAL_TX_PARITY_EN
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) par <= 1'b0;
        else          par <= par_n;
    end
`endif

endmodule

// File: tb/tb_lcd_serial_tx.sv
// Bench for lcd_serial_tx: a line receiver decodes TXD and checks it against a queue of written bytes.
module tb_lcd_serial_tx;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int BD = 4;
    localparam int SB = 1;
    localparam int GB = 3;
`ifdef LCD_SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME    = (1 + DW + PB + SB) * BD;
    localparam int GAP      = GB * BD;
    localparam int STOP_MID = (1 + DW + PB) * BD + BD / 2;

    logic          SYSCLK = 1'b0;
    logic          SYSRESET = 1'b1;
    logic          TXD;
    logic          BUSY;
    logic [2:0]    LEVEL;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    bit            rx_act = 1'b0;
    logic [DW-1:0] exp_q[$];
    int            start_q[$];

    lcd_serial_tx_if #(.DATA_W(DW)) wr ();

    lcd_serial_tx #(
        .DATA_W    (DW),
        .DEPTH     (DP),
        .BAUD_DIV  (BD),
        .STOP_BITS (SB),
        .CMD_PREFIX(8'hFE),
        .GAP_BITS  (GB)
    ) dut (
        .SYSCLK   (SYSCLK),
        .SYSRESET (SYSRESET),
        .wr       (wr),
        .TXD      (TXD),
        .BUSY     (BUSY),
        .LEVEL    (LEVEL)
    );

    initial forever #5 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    // Receiver: samples mid-bit, pops the scoreboard at the stop bit.
    initial begin : rx_mon
        int            rc;
        logic [DW-1:0] rb;
        logic          rp;
        logic          rst_s;
        logic [DW-1:0] e;
        rc = 0; rb = '0; rp = 1'b0;
        forever begin
            @(posedge SYSCLK);
            rst_s = SYSRESET;
            #1;
            if (rst_s) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (TXD === 1'b0) begin
                    rx_act = 1'b1;
                    rc = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                rc++;
                if (rc == BD / 2) begin
                    vectors++;
                    if (TXD !== 1'b0) begin
                        miscompares++;
                        $display("FAIL start_bit at cyc %0d: got %b want 0", cyc, TXD);
                    end
                end
                for (int i = 0; i < DW; i++)
                    if (rc == BD * (1 + i) + BD / 2) rb[i] = TXD;
                if (rc == BD * (1 + DW) + BD / 2) rp = TXD;
                if (rc == STOP_MID) begin
                    rx_act = 1'b0;
                    vectors++;
                    if (TXD !== 1'b1) begin
                        miscompares++;
                        $display("FAIL stop_bit at cyc %0d: got %b want 1", cyc, TXD);
                    end
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL rx_byte: got %h want <no frame>", rb);
                    end else begin
                        e = exp_q.pop_front();
                        if (rb !== e) begin
                            miscompares++;
                            $display("FAIL rx_byte: got %h want %h", rb, e);
                        end
`ifdef LCD_SERIAL_TX_PARITY_EN
                        vectors++;
                        if (rp !== ^e) begin
                            miscompares++;
                            $display("FAIL rx_parity for %h: got %b want %b", e, rp, ^e);
                        end
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] b, input bit expect_it, output int k);
        int n = 0;
        bit acc = 1'b0;
        wr.WR_DATA  = b;
        wr.WR_VALID = 1'b1;
        while (!acc && n < 200) begin
            acc = wr.WR_READY;
            tick();
            n++;
        end
        wr.WR_VALID = 1'b0;
        k = cyc;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL put_timeout: byte %h got not accepted want accepted", b);
        end else if (expect_it) begin
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((BUSY !== 1'b0 || rx_act) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: got busy after %0d cycles want idle", n);
        end
    endtask

    task automatic test_reset();
        SYSRESET = 1'b1;
        tick();
        tick();
        vectors++; if (TXD !== 1'b1)      begin miscompares++; $display("FAIL reset_txd: got %b want 1", TXD); end
        vectors++; if (wr.WR_READY !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", wr.WR_READY); end
        vectors++; if (BUSY !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        vectors++; if (LEVEL !== 3'd0)    begin miscompares++; $display("FAIL reset_level: got %0d want 0", LEVEL); end
        SYSRESET = 1'b0;
        tick();
    endtask

    task automatic test_single(input logic [DW-1:0] b);
        int k;
        int n = 0;
        start_q.delete();
        put(b, 1'b1, k);
        vectors++; if (LEVEL !== 3'd1) begin miscompares++; $display("FAIL single_level_k: got %0d want 1", LEVEL); end
        vectors++; if (BUSY !== 1'b1)  begin miscompares++; $display("FAIL single_busy_k: got %b want 1", BUSY); end
        tick();
        vectors++; if (TXD !== 1'b0)   begin miscompares++; $display("FAIL single_txd_k1: got %b want 0", TXD); end
        vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL single_level_k1: got %0d want 0", LEVEL); end
        while (BUSY === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        vectors++; if (n != FRAME) begin miscompares++; $display("FAIL single_busy_len %h: got %0d want %0d", b, n, FRAME); end
        wait_idle(50);
        vectors++;
        if (start_q.size() != 1 || start_q[0] != k + 1) begin
            miscompares++;
            $display("FAIL single_start: got %0d starts first at %0d want 1 at %0d", start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, k + 1);
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_left: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_cmd_gap();
        int k;
        logic [DW-1:0] seq[7] = '{8'hFE, 8'h01, 8'h33, 8'hFE, 8'hFE, 8'h22, 8'h33};
        int exp_d[6] = '{FRAME, FRAME + GAP, FRAME, FRAME, FRAME + GAP, FRAME};
        start_q.delete();
        for (int i = 0; i < 7; i++) put(seq[i], 1'b1, k);
        wait_idle(1000);
        vectors++;
        if (start_q.size() != 7) begin
            miscompares++;
            $display("FAIL cmd_frames: got %0d want 7", start_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (start_q[i + 1] - start_q[i] != exp_d[i]) begin
                    miscompares++;
                    $display("FAIL cmd_spacing[%0d]: got %0d want %0d", i, start_q[i + 1] - start_q[i], exp_d[i]);
                end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL cmd_left: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit acc;
        bit hit_full = 1'b0;
        int n;
        logic [DW-1:0] b;
        start_q.delete();
        for (int i = 0; i < 6; i++) begin
            b = DW'(8'hA0 + i);
            wr.WR_DATA  = b;
            wr.WR_VALID = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 200) begin
                acc = wr.WR_READY;
                tick();
                n++;
                if (LEVEL === 3'd4) begin
                    hit_full = 1'b1;
                    vectors++;
                    if (wr.WR_READY !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b want 0", wr.WR_READY); end
                end
            end
            if (acc) exp_q.push_back(b);
            else begin vectors++; miscompares++; $display("FAIL b2b_put_timeout: byte %h got not accepted want accepted", b); end
        end
        wr.WR_VALID = 1'b0;
        vectors++; if (!hit_full) begin miscompares++; $display("FAIL b2b_full_seen: got 0 want 1"); end
        wait_idle(1000);
        vectors++;
        if (start_q.size() != 6) begin
            miscompares++;
            $display("FAIL b2b_frames: got %0d want 6", start_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (start_q[i + 1] - start_q[i] != FRAME) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, start_q[i + 1] - start_q[i], FRAME);
                end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_left: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_full_pop();
        int k;
        bit acc = 1'b0;
        bit saw3 = 1'b0;
        for (int i = 0; i < 5; i++) put(DW'(8'h10 + i), 1'b1, k);
        vectors++; if (LEVEL !== 3'd4) begin miscompares++; $display("FAIL fullpop_filled: got %0d want 4", LEVEL); end
        wr.WR_DATA  = 8'h5A;
        wr.WR_VALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            acc = wr.WR_READY;
            tick();
            if (acc) break;
            if (LEVEL !== 3'd4) begin
                saw3 = 1'b1;
                vectors++;
                if (LEVEL !== 3'd3) begin miscompares++; $display("FAIL fullpop_level_on_pop: got %0d want 3", LEVEL); end
            end
        end
        wr.WR_VALID = 1'b0;
        if (acc) exp_q.push_back(8'h5A);
        vectors++; if (!saw3) begin miscompares++; $display("FAIL fullpop_saw_pop: got 0 want 1"); end
        vectors++; if (LEVEL !== 3'd4) begin miscompares++; $display("FAIL fullpop_after_write: got %0d want 4", LEVEL); end
        wait_idle(1000);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL fullpop_left: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int k;
        put(8'h55, 1'b0, k);
        put(8'h66, 1'b0, k);
        repeat (14) tick();
        SYSRESET = 1'b1;
        tick();
        vectors++; if (TXD !== 1'b1)   begin miscompares++; $display("FAIL midrst_txd: got %b want 1", TXD); end
        vectors++; if (LEVEL !== 3'd0) begin miscompares++; $display("FAIL midrst_level: got %0d want 0", LEVEL); end
        vectors++; if (BUSY !== 1'b0)  begin miscompares++; $display("FAIL midrst_busy: got %b want 0", BUSY); end
        SYSRESET = 1'b0;
        tick();
        start_q.delete();
        put(8'h3C, 1'b1, k);
        wait_idle(200);
        vectors++;
        if (start_q.size() != 1 || start_q[0] != k + 1) begin
            miscompares++;
            $display("FAIL midrst_restart: got %0d starts first at %0d want 1 at %0d", start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, k + 1);
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL midrst_left: got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        wr.WR_VALID = 1'b0;
        wr.WR_DATA  = '0;
        test_reset();
        test_single(8'h41);
        test_cmd_gap();
        test_back_to_back();
        test_full_pop();
        test_reset_mid();
`ifdef LCD_SERIAL_TX_PARITY_EN
        test_single(8'h07);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_serial_tx.md
# lcd_serial_tx

Parametrised, buffered serial transmitter that drives the serial-LCD link from the fabric side of the `lcd_display` design. It is the successor to the fixed 8N1 UART path currently used toward the screen. It accepts bytes on a valid/ready handshake into an internal FIFO and serialises them LSB-first. Data width, depth, baud divisor and stop bits are configurable. It automatically inserts an idle gap after LCD command bytes so the display controller has settling time.

## Interface
- `DATA_W`, 8: bits per character.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `BAUD_DIV`, 1042: SYSCLK cycles per bit (10 MHz / 9600).
- `STOP_BITS`, 1: 1 or 2.
- `CMD_PREFIX`, 8'hFE: byte value that marks the next byte as an LCD command.
- `GAP_BITS`, 10: idle bit-times inserted after a command byte.

- `SYSCLK`, in, 1: clock; all logic on the rising edge.
- `SYSRESET`, in, 1: synchronous, active-high reset.
- `WR_DATA`, in, DATA_W: byte to send.
- `WR_VALID`, in, 1: `WR_DATA` is valid.
- `WR_READY`, out, 1: FIFO not full; a write is accepted on an edge where `WR_VALID & WR_READY`.
- `TXD`, out, 1: serial line; idle high; registered.
- `BUSY`, out, 1: FSM not in IDLE, or FIFO not empty.
- `LEVEL`, out, $clog2(DEPTH+1): FIFO occupancy.

## Operation
- Reset values: `TXD`=1, `WR_READY`=1, `BUSY`=0, `LEVEL`=0. Reset flushes the FIFO, clears the command flag and forces IDLE.
- FSM states and transitions:
  - IDLE: if the FIFO is not empty, pop and go to START. The popped byte is latched into the shift register.
  - START: `TXD`=0.
  - DATA: `DATA_W` bits, LSB first.
  - PARITY: present only with the parity macro.
  - STOP: `TXD`=1 for `STOP_BITS` bits.
  - GAP: `TXD`=1 for `GAP_BITS` bits.
  - Every bit state lasts exactly `BAUD_DIV` cycles, timed by a bit counter that counts 0..BAUD_DIV-1. The counter restarts on every state entry.
- Command gap:
  - A sent byte equal to `CMD_PREFIX` sets `cmd_next`.
  - The following byte is treated as a command. After its STOP, the FSM enters GAP and `cmd_next` clears.
  - Two consecutive `CMD_PREFIX` bytes: the second one is the command. It gets a gap and does not re-arm the flag.
- End of STOP or GAP: if the FIFO is not empty, pop and go straight to START with no extra idle cycle. Otherwise go to IDLE.
- FIFO boundaries:
  - `WR_READY` = !full, computed from the registered occupancy.
  - A write while full is not accepted, even if a pop happens on the same edge.
  - A write and a pop on the same edge leave `LEVEL` unchanged.
  - Pointers wrap modulo `DEPTH`.
- Reset mid-frame: `TXD` returns to 1 on the reset edge. The partial character is abandoned and not retried.

## Timing
- Write accepted on edge k into an idle, empty block: pop on edge k+1, and `TXD` falls at edge k+1.
- Frame length = (1 + DATA_W + P + STOP_BITS) × BAUD_DIV cycles, where P is 1 with parity and 0 without.
- Command frames add GAP_BITS × BAUD_DIV cycles after the frame.
- `LEVEL` and `WR_READY` update on the edge after the write or pop.
- `BUSY` falls on the edge that enters IDLE with the FIFO empty.

## Configuration
- `LCD_SERIAL_TX_PARITY_EN` defined: a PARITY state is inserted after DATA. It transmits even parity, the XOR of the data bits.
- Undefined: there is no PARITY state, the frame is 8N1-style, and no parity logic is synthesised.

## Structure
- Shared package `lcd_pkg` holds:
  - the FSM state enum;
  - `LCD_CMD_PREFIX` (8'hFE);
  - the default `BAUD_DIV` constant for 10 MHz at 9600 baud.
- One sub-module, `lcd_tx_fifo`: synchronous FIFO, parametrised by `DATA_W`/`DEPTH`, with push/pop, full/empty and level outputs. The serialiser FSM lives in the top.

## Test plan
Bench parameters: BAUD_DIV=4, DEPTH=4, GAP_BITS=3.
1. Write 8'h41 while idle: `TXD` is low at k+1 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high. `BUSY` drops 40 cycles after k+1.
2. Write 8'hFE then 8'h01: the first frame has no gap. After the 8'h01 stop bit, `TXD` stays high for 12 cycles before the next queued byte starts.
3. Hold `WR_VALID` with 6 bytes: `WR_READY` goes low when `LEVEL`=4. All 6 bytes go out back-to-back with no idle cycle between frames.
4. Full FIFO, write on the pop edge: the write is not accepted and `LEVEL` goes 4→3.
5. Assert `SYSRESET` mid DATA of 8'h55: `TXD`=1, `LEVEL`=0, `BUSY`=0 on the next edge. The next write transmits cleanly.
6. With `LCD_SERIAL_TX_PARITY_EN` defined, send 8'h07: the parity bit is 1 and the frame is 44 cycles.
